// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic PORT_PIPE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational 2-way requester picker.
// DMEM_ARB_FIXED_PRIO_EN selects fixed port-0 priority; default is round robin on last.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant_idx,
  output logic       any
);

  assign any = |req;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign grant_idx = req[0] ? PORT_PIPE : PORT_DMA;
`else
  always_comb begin
    grant_idx = PORT_PIPE;
    if (req == 2'b11)
      grant_idx = ~last;
    else if (req[1])
      grant_idx = PORT_DMA;
  end
`endif

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-port data memory between the pipeline port (0) and the DMA port (1).
// Each access runs IDLE -> ACCESS -> RESP; DMEM_ARB_FIXED_PRIO_EN selects fixed priority.
module data_memory_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int W     = 31,
  parameter int CELLS = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       p0_req,
  input  logic       p0_we,
  input  logic [W:0] p0_addr,
  input  logic [W:0] p0_wdata,
  output logic       p0_gnt,
  output logic       p0_rsp_valid,
  output logic [W:0] p0_rdata,
  output logic       p0_rsp_err,
  input  logic       p1_req,
  input  logic       p1_we,
  input  logic [W:0] p1_addr,
  input  logic [W:0] p1_wdata,
  output logic       p1_gnt,
  output logic       p1_rsp_valid,
  output logic [W:0] p1_rdata,
  output logic       p1_rsp_err,
  output logic [W:0] mem_address,
  output logic [W:0] mem_write_data,
  output logic       mem_control_write,
  input  logic [W:0] mem_read_data
);

  localparam logic [W:0] MAX_ADDR = (W+1)'(CELLS);

  function automatic logic addr_ok(input logic [W:0] a);
    return a <= MAX_ADDR;
  endfunction

  function automatic logic [W:0] read_result(input logic ok, input logic we,
                                             input logic [W:0] data);
    return (ok && !we) ? data : '0;
  endfunction

  state_t     state;
  logic       last;
  logic       pick_idx;
  logic       pick_any;
  logic       sel_we;
  logic [W:0] sel_addr;
  logic [W:0] sel_wdata;
  logic       cmd_port_p0;
  logic       cmd_we_p0;
  logic       cmd_ok_p0;
  logic [W:0] rd_val;

  dmem_rr_pick u_pick (
    .req       ({p1_req, p0_req}),
    .last      (last),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  always_comb begin
    sel_we    = p0_we;
    sel_addr  = p0_addr;
    sel_wdata = p0_wdata;
    if (pick_idx == PORT_DMA) begin
      sel_we    = p1_we;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
    end
  end

  assign rd_val = read_result(cmd_ok_p0, cmd_we_p0, mem_read_data);

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign last = PORT_DMA;
`else
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      last <= PORT_DMA;
    else if (state == ST_IDLE && pick_any)
      last <= pick_idx;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      p0_gnt            <= 1'b0;
      p1_gnt            <= 1'b0;
      p0_rsp_valid      <= 1'b0;
      p1_rsp_valid      <= 1'b0;
      p0_rsp_err        <= 1'b0;
      p1_rsp_err        <= 1'b0;
      p0_rdata          <= '0;
      p1_rdata          <= '0;
      mem_address       <= '0;
      mem_write_data    <= '0;
      mem_control_write <= 1'b0;
      cmd_port_p0       <= PORT_PIPE;
      cmd_we_p0         <= 1'b0;
      cmd_ok_p0         <= 1'b0;
    end else begin
      p0_gnt            <= 1'b0;
      p1_gnt            <= 1'b0;
      p0_rsp_valid      <= 1'b0;
      p1_rsp_valid      <= 1'b0;
      mem_control_write <= 1'b0;
      case (state)
        // Stage p0: latch the winner's command; memory sees it from the next cycle on
        ST_IDLE: begin
          if (pick_any) begin
            cmd_port_p0       <= pick_idx;
            cmd_we_p0         <= sel_we;
            cmd_ok_p0         <= addr_ok(sel_addr);
            mem_address       <= sel_addr;
            mem_write_data    <= sel_wdata;
            mem_control_write <= sel_we & addr_ok(sel_addr);
            p0_gnt            <= (pick_idx == PORT_PIPE);
            p1_gnt            <= (pick_idx == PORT_DMA);
            state             <= ST_ACCESS;
          end
        end
        // Stage p1: capture read data at the end of ACCESS and present the response
        ST_ACCESS: begin
          if (cmd_port_p0 == PORT_PIPE) begin
            p0_rsp_valid <= 1'b1;
            p0_rdata     <= rd_val;
            p0_rsp_err   <= ~cmd_ok_p0;
          end else begin
            p1_rsp_valid <= 1'b1;
            p1_rdata     <= rd_val;
            p1_rsp_err   <= ~cmd_ok_p0;
          end
          state <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assert property (@(posedge clock) disable iff (reset) $onehot0({p0_gnt, p1_gnt}));
  assert property (@(posedge clock) disable iff (reset) $onehot0({p0_rsp_valid, p1_rsp_valid}));
  assert property (@(posedge clock) disable iff (reset) mem_control_write |-> state == ST_ACCESS);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Randomized bench for data_memory_arbiter with a cycle-count transaction model.
// Honors DMEM_ARB_FIXED_PRIO_EN for the expected arbitration order.
module tb_data_memory_arbiter;

  localparam int CELLS = 255;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [1:0]  gnt, rsp_valid, rsp_err;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_control_write;
  logic [31:0] tb_mem  [0:CELLS];
  logic [31:0] ref_mem [0:CELLS];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  // model state
  int          free_at = 0;
  int          gnt_cyc = -10;
  int          rsp_cyc = -10;
  int          gnt_port = 0;
  int          m_last = 1;
  bit          exp_wr, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  bit          chosen [2];
  int          lock_until [2];
  int          undo_addr;
  logic [31:0] undo_val;
  bit          undo_vld;

  // observations
  int          seen_gnt_cyc [2];
  int          seen_rsp_cyc [2];
  logic [31:0] seen_rdata [2];
  logic        seen_err [2];
  int          n_gnt [2];
  int          n_mcw = 0;
  int          g_seq [$];
  int          last_req_cyc = 0;

  data_memory_arbiter #(.W(31), .CELLS(CELLS)) dut (
    .clock             (clock),
    .reset             (reset),
    .p0_req            (req[0]),
    .p0_we             (we[0]),
    .p0_addr           (addr[0]),
    .p0_wdata          (wdata[0]),
    .p0_gnt            (gnt[0]),
    .p0_rsp_valid      (rsp_valid[0]),
    .p0_rdata          (rdata0),
    .p0_rsp_err        (rsp_err[0]),
    .p1_req            (req[1]),
    .p1_we             (we[1]),
    .p1_addr           (addr[1]),
    .p1_wdata          (wdata[1]),
    .p1_gnt            (gnt[1]),
    .p1_rsp_valid      (rsp_valid[1]),
    .p1_rdata          (rdata1),
    .p1_rsp_err        (rsp_err[1]),
    .mem_address       (mem_address),
    .mem_write_data    (mem_write_data),
    .mem_control_write (mem_control_write),
    .mem_read_data     (mem_read_data)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) if (mem_control_write) tb_mem[mem_address[7:0]] <= mem_write_data;
  assign mem_read_data = tb_mem[mem_address[7:0]];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int pick(bit r0, bit r1);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    return r0 ? 0 : 1;
`else
    if (r0 && r1) return 1 - m_last;
    return r0 ? 0 : 1;
`endif
  endfunction

  task automatic check_cycle();
    logic [31:0] rd;
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("p%0d_gnt", p), gnt[p], (cyc == gnt_cyc && gnt_port == p));
      chk($sformatf("p%0d_rsp_valid", p), rsp_valid[p], (cyc == rsp_cyc && gnt_port == p));
      rd = (p == 1) ? rdata1 : rdata0;
      if (gnt[p]) begin
        seen_gnt_cyc[p] = cyc;
        n_gnt[p]++;
        g_seq.push_back(p);
      end
      if (rsp_valid[p]) begin
        seen_rsp_cyc[p] = cyc;
        seen_rdata[p]   = rd;
        seen_err[p]     = rsp_err[p];
      end
      if (cyc == rsp_cyc && gnt_port == p) begin
        chk($sformatf("p%0d_rdata", p), rd, exp_rdata);
        chk($sformatf("p%0d_rsp_err", p), rsp_err[p], exp_err);
      end
    end
    chk("mem_control_write", mem_control_write, (cyc == gnt_cyc && exp_wr));
    if (mem_control_write) n_mcw++;
    if (cyc == gnt_cyc || cyc == rsp_cyc) chk("mem_address", mem_address, exp_addr);
    if (cyc == gnt_cyc && exp_wr) chk("mem_write_data", mem_write_data, exp_wdata);
  endtask

  // Called at a falling edge with inputs already driven; predicts, advances one cycle, checks.
  task automatic step();
    int w;
    if (cyc >= free_at && (req[0] || req[1])) begin
      w         = pick(req[0], req[1]);
      m_last    = w;
      gnt_port  = w;
      gnt_cyc   = cyc + 1;
      rsp_cyc   = cyc + 2;
      free_at   = cyc + 3;
      exp_addr  = addr[w];
      exp_wdata = wdata[w];
      exp_err   = (addr[w] > CELLS);
      exp_wr    = we[w] && !exp_err;
      exp_rdata = (!we[w] && !exp_err) ? ref_mem[addr[w]] : 32'h0;
      undo_vld  = exp_wr;
      if (exp_wr) begin
        undo_addr = addr[w];
        undo_val  = ref_mem[addr[w]];
        ref_mem[addr[w]] = wdata[w];
      end
      chosen[w]     = 1'b1;
      lock_until[w] = cyc + 2;
    end
    @(negedge clock);
    check_cycle();
  endtask

  task automatic do_access(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    we[p] = w; addr[p] = a; wdata[p] = d; req[p] = 1'b1;
    last_req_cyc = cyc;
    for (int i = 0; i < 8 && !chosen[p]; i++) step();
    step();
    req[p] = 1'b0;
    chosen[p] = 1'b0;
    step();
  endtask

  task automatic new_cmd(input int p);
    int r;
    r = $urandom_range(0, 9);
    we[p]    = $urandom_range(0, 1);
    addr[p]  = (r == 0) ? 32'(256 + $urandom_range(0, 100)) :
               (r == 1) ? 32'd255 : 32'($urandom_range(0, 15));
    wdata[p] = $urandom;
    req[p]   = 1'b1;
  endtask

  initial begin
    int base, ndiff;
    for (int i = 0; i <= CELLS; i++) begin tb_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    addr[0] = 0; addr[1] = 0; wdata[0] = 0; wdata[1] = 0;

    // reset values, sampled while reset is held
    @(negedge clock); @(negedge clock);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_err", rsp_err, 2'b00);
    chk("rst_rdata0", rdata0, 32'h0);
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_wdata", mem_write_data, 32'h0);
    chk("rst_mem_we", mem_control_write, 1'b0);
    chk("rst_state", dut.state, 0);
    reset = 1'b0;
    free_at = cyc;

    // both ports read continuously
    we = 2'b00; addr[0] = 5; addr[1] = 7; req = 2'b11;
    repeat (12) step();
    req = 2'b00; chosen[0] = 0; chosen[1] = 0;
    chk("t2_count", g_seq.size(), 4);
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      chk($sformatf("t2_seq%0d", i), g_seq[i], 0);
`else
      chk($sformatf("t2_seq%0d", i), g_seq[i], i % 2);
`endif
    end
    step(); step(); step();

    // write then read back on port 0
    do_access(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
    do_access(0, 1'b0, 32'd5, 32'h0);
    chk("t1_rdata", seen_rdata[0], 32'hDEAD_BEEF);
    chk("t1_err", seen_err[0], 1'b0);
    chk("t1_gnt_lat", seen_gnt_cyc[0] - last_req_cyc, 1);
    chk("t1_rsp_lat", seen_rsp_cyc[0] - last_req_cyc, 2);

    // out-of-range write from the DMA port must not touch memory
    do_access(0, 1'b1, 32'd0, 32'h1234_5678);
    base = n_mcw;
    do_access(1, 1'b1, 32'd256, 32'hBAD0_0256);
    chk("t3_no_write", n_mcw - base, 0);
    chk("t3_err", seen_err[1], 1'b1);
    chk("t3_rdata", seen_rdata[1], 32'h0);
    do_access(0, 1'b0, 32'd0, 32'h0);
    chk("t3_addr0", seen_rdata[0], 32'h1234_5678);

    // DMA request raised and withdrawn while the arbiter is busy
    we[0] = 1'b0; addr[0] = 3; req[0] = 1'b1;
    step();
    we[1] = 1'b1; addr[1] = 4; wdata[1] = $urandom; req[1] = 1'b1;
    step();
    req = 2'b00; chosen[0] = 0;
    base = n_gnt[1] + n_mcw;
    repeat (4) step();
    chk("t5_no_activity", n_gnt[1] + n_mcw - base, 0);

    // reset during the ACCESS cycle of a write
    we[0] = 1'b1; addr[0] = 9; wdata[0] = 32'hA5A5_0009; req[0] = 1'b1;
    step();
    reset = 1'b1;
    #1;
    chk("t4_mem_we", mem_control_write, 1'b0);
    chk("t4_gnt", gnt, 2'b00);
    chk("t4_state", dut.state, 0);
    if (undo_vld) ref_mem[undo_addr] = undo_val;
    req = 2'b00; chosen[0] = 0; chosen[1] = 0;
    gnt_cyc = -10; rsp_cyc = -10; m_last = 1;
    @(negedge clock);
    reset = 1'b0;
    free_at = cyc;
    step(); step(); step();
    we = 2'b00; addr[0] = 9; addr[1] = 9; req = 2'b11;
    step();
    chk("t4_tie_p0", gnt, 2'b01);
    step();
    req = 2'b00; chosen[0] = 0; chosen[1] = 0;
    step();

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (cyc >= lock_until[p]) begin
          if (chosen[p]) begin
            chosen[p] = 1'b0;
            if ($urandom_range(0, 1) == 0) req[p] = 1'b0;
            else new_cmd(p);
          end else if (req[p]) begin
            if ($urandom_range(0, 7) == 0) req[p] = 1'b0;
          end else if ($urandom_range(0, 1) == 1) begin
            new_cmd(p);
          end
        end
      end
      step();
    end
    req = 2'b00;
    repeat (4) step();

    ndiff = 0;
    for (int i = 0; i <= CELLS; i++) if (tb_mem[i] !== ref_mem[i]) ndiff++;
    chk("mem_image", ndiff, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
